// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM state
// encodings and the sizing helper for the bit counter.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    // Bit counter width; WIDTH >= 2 so $clog2 never collapses to zero.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_addsub_if.sv
// Request/response bundle of the serial adder: operands and mode go in
// with start, busy/done and the final result come back.
interface serial_addsub_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;

    // Requester side
    modport master (
        output start, sub, a, b,
        input  busy, done, result, cout, overflow
    );

    // Arithmetic unit side
    modport slave (
        input  start, sub, a, b,
        output busy, done, result, cout, overflow
    );
endinterface

// File: rtl/serial_addsub_fa.sv
// One-bit full adder cell: the only arithmetic in the serial unit.
module serial_addsub_fa (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic s_o,
    output logic cout_o
);
    assign s_o    = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);
endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor. Operands are shifted LSB-first through a
// single full-adder cell with a carry flop; subtraction is A + ~B + 1, the
// +1 coming from preloading the carry with the sub flag.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_addsub_if.slave bus
);
    localparam int                CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state_q;
    logic [WIDTH-1:0]   sha_q;
    logic [WIDTH-1:0]   shb_q;
    logic [WIDTH-1:0]   result_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               carry_q;
    logic               c_msb_q;   // carry into the MSB slice, for overflow
    logic               busy_q;
    logic               done_q;
    logic               cout_q;
    logic               ovf_q;

    logic               sum_d;
    logic               carry_d;

    // Bit slice: current LSBs of both shift registers plus the carry flop.
    serial_addsub_fa u_fa (
        .a_i    (sha_q[0]),
        .b_i    (shb_q[0]),
        .cin_i  (carry_q),
        .s_o    (sum_d),
        .cout_o (carry_d)
    );

    // Control FSM with datapath registers; all outputs are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            sha_q    <= '0;
            shb_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            c_msb_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // Operands are captured here only; later input changes
                    // cannot disturb a running operation.
                    if (bus.start) begin
                        sha_q   <= bus.a;
                        shb_q   <= bus.sub ? ~bus.b : bus.b;
                        carry_q <= bus.sub;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    result_q <= {sum_d, result_q[WIDTH-1:1]};
                    sha_q    <= sha_q >> 1;
                    shb_q    <= shb_q >> 1;
                    carry_q  <= carry_d;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        c_msb_q <= carry_q;
                        busy_q  <= 1'b0;
                        state_q <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    // Signed overflow: carry into MSB differs from carry out.
                    done_q  <= 1'b1;
                    cout_q  <= carry_q;
                    ovf_q   <= c_msb_q ^ carry_q;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub (WIDTH=8): directed cases, ignored
// start, mid-run reset, back-to-back and random ops against a model.
module tb_serial_addsub;
    localparam int W   = 8;
    localparam int LAT = W + 1;

    typedef struct packed {
        logic [W-1:0] r;
        logic         c;
        logic         v;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t sbq[$];

    serial_addsub_if #(.WIDTH(W)) bus ();

    serial_addsub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural reference using signed-overflow sign rules.
    function automatic exp_t model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t        e;
        logic [W:0]  full;
        if (s) full = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        else   full = {1'b0, a} + {1'b0, b};
        e.r = full[W-1:0];
        e.c = full[W];
        if (s) e.v = (a[W-1] != b[W-1]) && (e.r[W-1] != a[W-1]);
        else   e.v = (a[W-1] == b[W-1]) && (e.r[W-1] != a[W-1]);
        return e;
    endfunction

    // Waits (bounded) for done; returns edges counted after acceptance.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    // Pops the scoreboard and compares the visible result.
    task automatic check_result(input string name);
        exp_t e;
        n_chk++;
        if (sbq.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty at done", name);
        end else begin
            e = sbq.pop_front();
            if (bus.result !== e.r) begin
                n_fail++;
                $display("FAIL %s result: got %0d expected %0d", name, bus.result, e.r);
            end
            n_chk++;
            if (bus.cout !== e.c) begin
                n_fail++;
                $display("FAIL %s cout: got %b expected %b", name, bus.cout, e.c);
            end
            n_chk++;
            if (bus.overflow !== e.v) begin
                n_fail++;
                $display("FAIL %s overflow: got %b expected %b", name, bus.overflow, e.v);
            end
        end
    endtask

    // One operation: pulse start, check busy, latency, result, pulse width.
    task automatic do_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit scramble, input string name);
        int           cyc;
        logic [W-1:0] held;
        sbq.push_back(model(s, a, b));
        bus.start = 1'b1; bus.sub = s; bus.a = a; bus.b = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        if (scramble) begin
            bus.a = W'($urandom); bus.b = W'($urandom); bus.sub = 1'($urandom);
        end
        n_chk++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s busy after accept: got %b expected 1", name, bus.busy);
        end
        wait_done(cyc);
        n_chk++;
        if (cyc != LAT) begin
            n_fail++;
            $display("FAIL %s latency: got %0d expected %0d", name, cyc, LAT);
        end
        n_chk++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy at done: got %b expected 0", name, bus.busy);
        end
        check_result(name);
        held = bus.result;
        @(posedge clk); #1;
        n_chk++;
        if (bus.done !== 1'b0 || bus.result !== held) begin
            n_fail++;
            $display("FAIL %s hold after done: done=%b result=%0d expected done=0 result=%0d",
                     name, bus.done, bus.result, held);
        end
    endtask

    task automatic test_reset();
        n_chk++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== '0 ||
            bus.cout !== 1'b0 || bus.overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset state: busy=%b done=%b result=%0d cout=%b ovf=%b expected all 0",
                     bus.busy, bus.done, bus.result, bus.cout, bus.overflow);
        end
    endtask

    task automatic test_directed();
        do_op(1'b0, 8'd3,   8'd5,   1'b1, "add_3_5");
        do_op(1'b0, 8'd200, 8'd100, 1'b1, "add_200_100");
        do_op(1'b0, 8'd127, 8'd1,   1'b1, "add_127_1");
        do_op(1'b1, 8'd5,   8'd3,   1'b1, "sub_5_3");
        do_op(1'b1, 8'd3,   8'd5,   1'b1, "sub_3_5");
        do_op(1'b1, 8'd128, 8'd1,   1'b1, "sub_128_1");
    endtask

    task automatic test_ignore_start();
        int ndone = 0;
        sbq.push_back(model(1'b0, 8'd3, 8'd5));
        bus.start = 1'b1; bus.sub = 1'b0; bus.a = 8'd3; bus.b = 8'd5;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        bus.start = 1'b1; bus.sub = 1'b1; bus.a = 8'd100; bus.b = 8'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (bus.done === 1'b1) begin
                ndone++;
                if (ndone == 1) check_result("ignore_start");
            end
            @(posedge clk); #1;
        end
        n_chk++;
        if (ndone != 1) begin
            n_fail++;
            $display("FAIL ignore_start done count: got %0d expected 1", ndone);
        end
        sbq.delete();
    endtask

    task automatic test_reset_mid();
        int ndone = 0;
        do_op(1'b1, 8'd128, 8'd1, 1'b0, "pre_reset_sub");
        bus.start = 1'b1; bus.sub = 1'b0; bus.a = 8'hFF; bus.b = 8'hFF;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== '0 ||
            bus.cout !== 1'b0 || bus.overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid async clear: busy=%b done=%b result=%0d cout=%b ovf=%b expected all 0",
                     bus.busy, bus.done, bus.result, bus.cout, bus.overflow);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            if (bus.done === 1'b1) ndone++;
            @(posedge clk); #1;
        end
        n_chk++;
        if (ndone != 0) begin
            n_fail++;
            $display("FAIL reset_mid spurious done: got %0d expected 0", ndone);
        end
        do_op(1'b0, 8'd1, 8'd1, 1'b0, "post_reset_add");
    endtask

    task automatic test_back_to_back();
        int cyc;
        sbq.push_back(model(1'b0, 8'd10, 8'd20));
        sbq.push_back(model(1'b1, 8'd50, 8'd70));
        bus.start = 1'b1; bus.sub = 1'b0; bus.a = 8'd10; bus.b = 8'd20;
        @(posedge clk); #1;
        bus.sub = 1'b1; bus.a = 8'd50; bus.b = 8'd70;
        wait_done(cyc);
        n_chk++;
        if (cyc != LAT) begin
            n_fail++;
            $display("FAIL b2b first latency: got %0d expected %0d", cyc, LAT);
        end
        check_result("b2b_first");
        @(posedge clk); #1;
        bus.start = 1'b0;
        n_chk++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b retrigger busy: got %b expected 1", bus.busy);
        end
        wait_done(cyc);
        n_chk++;
        if (cyc != LAT) begin
            n_fail++;
            $display("FAIL b2b second latency: got %0d expected %0d", cyc, LAT);
        end
        check_result("b2b_second");
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 1000; i++)
            do_op(1'($urandom), W'($urandom), W'($urandom), 1'b1, "random");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.start = 1'b0; bus.sub = 1'b0; bus.a = '0; bus.b = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_directed();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
